// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and address check for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_ALIGN_BITS = 2;
    localparam int CNT_W           = 4;

    // A byte address is rejected when it is not word aligned or lies beyond the RAM.
    function automatic logic addr_err(input logic [31:0] addr, input int addr_bits);
        return (addr[WORD_ALIGN_BITS-1:0] != '0) ||
               ((addr >> (addr_bits + WORD_ALIGN_BITS)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// rtl/dmem_word_ram.sv - single-port word RAM, synchronous write-first with registered read
module dmem_word_ram #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] index,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
            rdata      <= wdata;
        end else begin
            rdata      <= mem[index];
        end
    end

endmodule

// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - wait-state data-memory responder with ready/err handshake
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                lat_we;
    logic [31:0]         lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rdata_hold;
    logic                err_q;

    logic                sel_we;
    logic [31:0]         sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_err;
    logic                enter_resp;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    // With zero latency the RAM is accessed on the acceptance edge itself, so the
    // live request is used in IDLE and the latched copy everywhere else.
    always_comb begin
        sel_we     = (state == IDLE) ? we    : lat_we;
        sel_addr   = (state == IDLE) ? addr  : lat_addr;
        sel_wdata  = (state == IDLE) ? wdata : lat_wdata;
        sel_err    = addr_err(sel_addr, ADDR_BITS);
        enter_resp = ((state == IDLE) && req && (LAT == '0)) ||
                     ((state == WAIT) && (cnt == CNT_W'(1)));
        ram_we     = enter_resp && sel_we && !sel_err && !reset;
    end

    dmem_word_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .index (sel_addr[ADDR_BITS+1:WORD_ALIGN_BITS]),
        .wdata (sel_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_hold <= '0;
            err_q      <= 1'b0;
        end else begin
            if (enter_resp) begin
                err_q <= sel_err;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        cnt       <= LAT;
                        state     <= (LAT == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    rdata_hold <= rdata;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rdata = (state == RESP) ? (err_q ? '0 : ram_rdata) : rdata_hold;
    assign ready = (state == RESP);
    assign err   = (state == RESP) && err_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - directed bench for the data-memory responder (LATENCY 2 and 0)
module tb_dmem_wait_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, we_a, ready_a, err_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ready_b, err_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_wait_responder #(.ADDR_BITS(6), .LATENCY(2), .DATA_W(32)) dut_a (
        .clk   (clk),
        .reset (reset),
        .req   (req_a),
        .we    (we_a),
        .addr  (addr_a),
        .wdata (wdata_a),
        .rdata (rdata_a),
        .ready (ready_a),
        .err   (err_a),
        .busy  (busy_a)
    );

    dmem_wait_responder #(.ADDR_BITS(6), .LATENCY(0), .DATA_W(32)) dut_b (
        .clk   (clk),
        .reset (reset),
        .req   (req_b),
        .we    (we_b),
        .addr  (addr_b),
        .wdata (wdata_b),
        .rdata (rdata_b),
        .ready (ready_b),
        .err   (err_b),
        .busy  (busy_b)
    );

    // Issues one request on the LATENCY=2 instance and reports edges-to-ready (-1 on timeout).
    task automatic txn_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int n);
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        @(posedge clk); #1;
        req_a = 1'b0;
        n  = -1;
        rd = 'x;
        er = 1'bx;
        for (int i = 0; i < 20; i++) begin
            if (ready_a) begin
                n  = i;
                rd = rdata_a;
                er = err_a;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ready_a, err_a, busy_a, rdata_a} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_a: got ready=%b err=%b busy=%b rdata=%h, want all 0",
                     ready_a, err_a, busy_a, rdata_a);
        end
        n_checks++;
        if ({ready_b, err_b, busy_b, rdata_b} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_b: got ready=%b err=%b busy=%b rdata=%h, want all 0",
                     ready_b, err_b, busy_b, rdata_b);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({ready_a, err_a, busy_a, rdata_a} !== 35'd0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got ready=%b err=%b busy=%b rdata=%h, want all 0",
                         i, ready_a, err_a, busy_a, rdata_a);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          n;
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h10; wdata_a = 32'hCAFEBABE;
        @(posedge clk); #1;
        req_a = 1'b0;
        n_checks++;
        if ({busy_a, ready_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL store_busy: got busy=%b ready=%b, want busy=1 ready=0", busy_a, ready_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({busy_a, ready_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL store_wait: got busy=%b ready=%b, want busy=1 ready=0", busy_a, ready_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ready_a, err_a, rdata_a} !== {2'b10, 32'hCAFEBABE}) begin
            n_fail++;
            $display("FAIL store_resp: got ready=%b err=%b rdata=%h, want 1 0 cafebabe",
                     ready_a, err_a, rdata_a);
        end
        @(posedge clk); #1;
        txn_a(1'b0, 32'h10, 32'h0, rd, er, n);
        n_checks++;
        if (n !== 2 || er !== 1'b0 || rd !== 32'hCAFEBABE) begin
            n_fail++;
            $display("FAIL load_0x10: got edges=%0d err=%b rdata=%h, want 2 0 cafebabe", n, er, rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          n;
        txn_a(1'b1, 32'h0, 32'h0BADF00D, rd, er, n);
        n_checks++;
        if (n !== 2 || er !== 1'b0 || rd !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL store_idx0: got edges=%0d err=%b rdata=%h, want 2 0 0badf00d", n, er, rd);
        end
        txn_a(1'b0, 32'h6, 32'h0, rd, er, n);
        n_checks++;
        if (n !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL misaligned_load: got edges=%0d err=%b rdata=%h, want 2 1 0", n, er, rd);
        end
        txn_a(1'b1, 32'h400, 32'hDEADDEAD, rd, er, n);
        n_checks++;
        if (n !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL range_store: got edges=%0d err=%b rdata=%h, want 2 1 0", n, er, rd);
        end
        n_checks++;
        if (rdata_a !== 32'h0) begin
            n_fail++;
            $display("FAIL rdata_hold_err: got %h, want 0", rdata_a);
        end
        txn_a(1'b0, 32'h0, 32'h0, rd, er, n);
        n_checks++;
        if (n !== 2 || er !== 1'b0 || rd !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL idx0_unchanged: got edges=%0d err=%b rdata=%h, want 2 0 0badf00d", n, er, rd);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] rd;
        logic        er;
        int          n;
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h10; wdata_a = 32'h0;
        @(posedge clk); #1;
        addr_a = 32'h20; we_a = 1'b1; wdata_a = 32'h11111111;
        @(posedge clk); #1;
        n_checks++;
        if ({busy_a, ready_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL busy_wait: got busy=%b ready=%b, want 1 0", busy_a, ready_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ready_a, err_a, rdata_a} !== {2'b10, 32'hCAFEBABE}) begin
            n_fail++;
            $display("FAIL busy_resp: got ready=%b err=%b rdata=%h, want 1 0 cafebabe",
                     ready_a, err_a, rdata_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({busy_a, ready_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL resp_req_ignored: got busy=%b ready=%b, want 0 0", busy_a, ready_a);
        end
        @(posedge clk); #1;
        req_a = 1'b0;
        n_checks++;
        if ({busy_a, ready_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL second_accept: got busy=%b ready=%b, want 1 0", busy_a, ready_a);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({ready_a, err_a, rdata_a} !== {2'b10, 32'h11111111}) begin
            n_fail++;
            $display("FAIL second_resp: got ready=%b err=%b rdata=%h, want 1 0 11111111",
                     ready_a, err_a, rdata_a);
        end
        @(posedge clk); #1;
        txn_a(1'b0, 32'h10, 32'h0, rd, er, n);
        n_checks++;
        if (n !== 2 || er !== 1'b0 || rd !== 32'hCAFEBABE) begin
            n_fail++;
            $display("FAIL reload_0x10: got edges=%0d err=%b rdata=%h, want 2 0 cafebabe", n, er, rd);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        logic        er;
        int          n;
        logic        saw_ready;
        txn_a(1'b1, 32'h08, 32'hA5A5A5A5, rd, er, n);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h08; wdata_a = 32'h12345678;
        @(posedge clk); #1;
        req_a = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({busy_a, ready_a, rdata_a} !== 34'd0) begin
            n_fail++;
            $display("FAIL midop_reset: got busy=%b ready=%b rdata=%h, want 0 0 0",
                     busy_a, ready_a, rdata_a);
        end
        saw_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ready_a !== 1'b0) saw_ready = 1'b1;
        end
        n_checks++;
        if (saw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_ready: got ready seen=%b, want 0", saw_ready);
        end
        txn_a(1'b0, 32'h08, 32'h0, rd, er, n);
        n_checks++;
        if (n !== 2 || er !== 1'b0 || rd !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL midop_old_value: got edges=%0d err=%b rdata=%h, want 2 0 a5a5a5a5", n, er, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ready;
        req_b = 1'b1; we_b = 1'b1; addr_b = 32'h04; wdata_b = 32'h55AA55AA;
        @(posedge clk); #1;
        we_b = 1'b0;
        n_checks++;
        if ({ready_b, err_b, busy_b, rdata_b} !== {3'b101, 32'h55AA55AA}) begin
            n_fail++;
            $display("FAIL lat0_store: got ready=%b err=%b busy=%b rdata=%h, want 1 0 1 55aa55aa",
                     ready_b, err_b, busy_b, rdata_b);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ready_b, busy_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL lat0_resp_ignored: got ready=%b busy=%b, want 0 0", ready_b, busy_b);
        end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            exp_ready = (i % 2 == 1);
            n_checks++;
            if (ready_b !== exp_ready || err_b !== 1'b0 || rdata_b !== 32'h55AA55AA) begin
                n_fail++;
                $display("FAIL lat0_b2b_edge%0d: got ready=%b err=%b rdata=%h, want %b 0 55aa55aa",
                         i, ready_b, err_b, rdata_b, exp_ready);
            end
        end
        req_b = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
